// File: rtl/membus_pkg.sv
// Shared types and helpers for the N-master memory-bus arbiter.
package membus_pkg;

  localparam logic [1:0] IO_TAG_DEFAULT = 2'b11;

  typedef enum logic {
    REG_RAM = 1'b0,
    REG_IO  = 1'b1
  } region_e;

  // Width of a master index; never narrower than one bit.
  function automatic int midx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // IO region is tagged by the two address bits at [aw:aw-1].
  function automatic region_e decode_region(input logic [31:0] a, input int aw,
                                            input logic [1:0] tag);
    return (2'(a >> (aw - 1)) == tag) ? REG_IO : REG_RAM;
  endfunction

endpackage

// File: rtl/membus_arbiter_if.sv
// Bus bundle between the requesting masters, the RAM/IO slaves and the arbiter.
// master: the requester/slave side of the bench or system; slave: the arbiter itself.
interface membus_arbiter_if #(
  parameter int N_MASTERS      = 2,
  parameter int RAM_ADDR_WIDTH = 17
);
  logic                        pause_in;
  logic [N_MASTERS-1:0]        m_req_in;
  logic [N_MASTERS-1:0]        m_lock_in;
  logic [N_MASTERS*32-1:0]     m_a_in;
  logic [N_MASTERS-1:0]        m_wr_in;
  logic [N_MASTERS*8-1:0]      m_dout_in;
  logic [N_MASTERS-1:0]        m_gnt_out;
  logic [N_MASTERS-1:0]        m_rvalid_out;
  logic [7:0]                  m_din_out;
  logic                        ram_en_out;
  logic [RAM_ADDR_WIDTH-1:0]   ram_a_out;
  logic                        ram_wr_out;
  logic [7:0]                  ram_d_out;
  logic [7:0]                  ram_d_in;
  logic                        io_en_out;
  logic [2:0]                  io_sel_out;
  logic                        io_wr_out;
  logic [7:0]                  io_d_out;
  logic [7:0]                  io_d_in;
  logic                        io_full_in;

  modport master (
    output pause_in, m_req_in, m_lock_in, m_a_in, m_wr_in, m_dout_in,
           ram_d_in, io_d_in, io_full_in,
    input  m_gnt_out, m_rvalid_out, m_din_out,
           ram_en_out, ram_a_out, ram_wr_out, ram_d_out,
           io_en_out, io_sel_out, io_wr_out, io_d_out
  );

  modport slave (
    input  pause_in, m_req_in, m_lock_in, m_a_in, m_wr_in, m_dout_in,
           ram_d_in, io_d_in, io_full_in,
    output m_gnt_out, m_rvalid_out, m_din_out,
           ram_en_out, ram_a_out, ram_wr_out, ram_d_out,
           io_en_out, io_sel_out, io_wr_out, io_d_out
  );
endinterface

// File: rtl/membus_picker.sv
// One-hot winner selection: master 0 absolute priority, then masters 1..N-1.
// MEMBUS_RR_EN selects round-robin among 1..N-1; otherwise lowest index wins.
module membus_picker
  import membus_pkg::*;
#(
  parameter int  N_MASTERS = 2,
  localparam int MW        = midx_w(N_MASTERS)
) (
  input  logic [N_MASTERS-1:0] elig,
`ifdef MEMBUS_RR_EN
  input  logic [MW-1:0]        rr_ptr,
`endif
  output logic [N_MASTERS-1:0] pick
);

`ifdef MEMBUS_RR_EN
  int            rr_c;
  logic [MW-1:0] rr_idx;
  logic          found;

  // Search starts just after the last winner and wraps back to 1, never to 0.
  always_comb begin
    pick   = '0;
    found  = 1'b0;
    rr_c   = 0;
    rr_idx = '0;
    if (elig[0]) begin
      pick[0] = 1'b1;
    end else begin
      for (int k = 1; k < N_MASTERS; k++) begin
        rr_c = int'(rr_ptr) + k;
        if (rr_c >= N_MASTERS) rr_c = rr_c - (N_MASTERS - 1);
        rr_idx = MW'(rr_c);
        if (!found && elig[rr_idx]) begin
          pick[rr_idx] = 1'b1;
          found        = 1'b1;
        end
      end
    end
  end
`else
  always_comb begin
    pick = '0;
    if (elig[0]) begin
      pick[0] = 1'b1;
    end else begin
      for (int i = N_MASTERS - 1; i >= 1; i--) begin
        if (elig[i]) begin
          pick    = '0;
          pick[i] = 1'b1;
        end
      end
    end
  end
`endif

endmodule

// File: rtl/membus_arbiter.sv
// N-master byte bus arbiter with RAM/IO decode, burst locking, IO backpressure and read return.
// MEMBUS_RR_EN enables round-robin among masters 1..N-1 (fixed priority otherwise).
module membus_arbiter
  import membus_pkg::*;
#(
  parameter int         N_MASTERS      = 2,
  parameter int         RAM_ADDR_WIDTH = 17,
  parameter logic [1:0] IO_TAG         = IO_TAG_DEFAULT
) (
  input logic             clk_in,
  input logic             rst_in,
  membus_arbiter_if.slave bus
);

  localparam int MW = midx_w(N_MASTERS);

  logic [31:0]          a_arr [N_MASTERS];
  logic [7:0]           d_arr [N_MASTERS];
  logic [N_MASTERS-1:0] elig, pick, gnt;
  logic [MW-1:0]        owner_q, win_idx, rmst_q;
  logic                 locked_q, rvalid_q, any_gnt, hold;
  region_e              rsel_q, win_reg;
`ifdef MEMBUS_RR_EN
  logic [MW-1:0]        rr_ptr_q;
`endif

  // An IO write facing a full output buffer is simply not eligible; the master waits.
  always_comb begin
    for (int i = 0; i < N_MASTERS; i++) begin
      a_arr[i] = bus.m_a_in[32*i +: 32];
      d_arr[i] = bus.m_dout_in[8*i +: 8];
      elig[i]  = bus.m_req_in[i] &&
                 !(decode_region(a_arr[i], RAM_ADDR_WIDTH, IO_TAG) == REG_IO &&
                   bus.m_wr_in[i] && bus.io_full_in);
    end
  end

  membus_picker #(.N_MASTERS(N_MASTERS)) u_picker (
    .elig   (elig),
`ifdef MEMBUS_RR_EN
    .rr_ptr (rr_ptr_q),
`endif
    .pick   (pick)
  );

  // A requesting lock owner overrides everyone, even when it is itself stalled.
  always_comb begin
    gnt  = '0;
    hold = locked_q && bus.m_req_in[owner_q];
    if (!bus.pause_in && !rst_in) begin
      if (hold) begin
        if (elig[owner_q]) gnt[owner_q] = 1'b1;
      end else begin
        gnt = pick;
      end
    end
  end

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (gnt[i]) win_idx = MW'(i);
    end
  end

  assign any_gnt       = |gnt;
  assign win_reg       = decode_region(a_arr[win_idx], RAM_ADDR_WIDTH, IO_TAG);
  assign bus.m_gnt_out = gnt;

  always_comb begin
    bus.ram_en_out = 1'b0;
    bus.ram_a_out  = '0;
    bus.ram_wr_out = 1'b0;
    bus.ram_d_out  = '0;
    bus.io_en_out  = 1'b0;
    bus.io_sel_out = '0;
    bus.io_wr_out  = 1'b0;
    bus.io_d_out   = '0;
    if (any_gnt) begin
      if (win_reg == REG_IO) begin
        bus.io_en_out  = 1'b1;
        bus.io_sel_out = a_arr[win_idx][2:0];
        bus.io_wr_out  = bus.m_wr_in[win_idx];
        bus.io_d_out   = d_arr[win_idx];
      end else begin
        bus.ram_en_out = 1'b1;
        bus.ram_a_out  = a_arr[win_idx][RAM_ADDR_WIDTH-1:0];
        bus.ram_wr_out = bus.m_wr_in[win_idx];
        bus.ram_d_out  = d_arr[win_idx];
      end
    end
  end

  always_comb begin
    bus.m_rvalid_out = '0;
    bus.m_din_out    = '0;
    if (rvalid_q) begin
      bus.m_rvalid_out[rmst_q] = 1'b1;
      bus.m_din_out            = (rsel_q == REG_IO) ? bus.io_d_in : bus.ram_d_in;
    end
  end

  // Without a grant the lock survives only while the owner keeps both req and lock high.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      owner_q  <= '0;
      locked_q <= 1'b0;
      rvalid_q <= 1'b0;
      rmst_q   <= '0;
      rsel_q   <= REG_RAM;
`ifdef MEMBUS_RR_EN
      rr_ptr_q <= MW'(N_MASTERS - 1);
`endif
    end else begin
      rvalid_q <= 1'b0;
      if (any_gnt) begin
        owner_q  <= win_idx;
        locked_q <= bus.m_lock_in[win_idx];
`ifdef MEMBUS_RR_EN
        if (win_idx != '0) rr_ptr_q <= win_idx;
`endif
        if (!bus.m_wr_in[win_idx]) begin
          rvalid_q <= 1'b1;
          rmst_q   <= win_idx;
          rsel_q   <= win_reg;
        end
      end else if (!bus.pause_in) begin
        locked_q <= locked_q && bus.m_req_in[owner_q] && bus.m_lock_in[owner_q];
      end
    end
  end

endmodule

// File: tb/tb_membus_arbiter.sv
// Self-checking bench for membus_arbiter (N_MASTERS=4): directed scenarios plus random traffic
// compared every cycle against a rule-level reference model.
module tb_membus_arbiter;

  localparam int NM = 4;
  localparam int AW = 17;

  logic clk, rst;
  int   checks   = 0;
  int   failures = 0;

  membus_arbiter_if #(.N_MASTERS(NM), .RAM_ADDR_WIDTH(AW)) bus ();

  membus_arbiter #(.N_MASTERS(NM), .RAM_ADDR_WIDTH(AW)) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // reference model state
  int mo_owner;
  bit mo_locked;
  bit pv;
  int pm;
  bit pio;
`ifdef MEMBUS_RR_EN
  int mo_rr;
`endif

  logic [NM-1:0] last_gnt, last_rv;
  logic [7:0]    last_din;
  logic          last_iowr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] addr_of(input int i);
    return bus.m_a_in[32*i +: 32];
  endfunction

  function automatic bit is_io(input logic [31:0] a);
    return a[AW] && a[AW-1];
  endfunction

  task automatic model_reset();
    mo_owner  = 0;
    mo_locked = 0;
    pv        = 0;
    pm        = 0;
    pio       = 0;
`ifdef MEMBUS_RR_EN
    mo_rr     = NM - 1;
`endif
  endtask

  function automatic int model_winner();
    bit e [NM];
    for (int i = 0; i < NM; i++)
      e[i] = bus.m_req_in[i] && !(is_io(addr_of(i)) && bus.m_wr_in[i] && bus.io_full_in);
    if (rst || bus.pause_in) return -1;
    if (mo_locked && bus.m_req_in[mo_owner]) return e[mo_owner] ? mo_owner : -1;
    if (e[0]) return 0;
`ifdef MEMBUS_RR_EN
    for (int k = 1; k < NM; k++) begin
      int c;
      c = mo_rr + k;
      if (c >= NM) c = c - (NM - 1);
      if (e[c]) return c;
    end
`else
    for (int i = 1; i < NM; i++) if (e[i]) return i;
`endif
    return -1;
  endfunction

  task automatic set_m(input int i, input logic req, input logic lock, input logic wr,
                       input logic [31:0] a, input logic [7:0] d);
    bus.m_req_in[i]        = req;
    bus.m_lock_in[i]       = lock;
    bus.m_wr_in[i]         = wr;
    bus.m_a_in[32*i +: 32] = a;
    bus.m_dout_in[8*i +: 8] = d;
  endtask

  task automatic idle_all();
    for (int i = 0; i < NM; i++) set_m(i, 1'b0, 1'b0, 1'b0, 32'h0, 8'h0);
    bus.pause_in   = 1'b0;
    bus.io_full_in = 1'b0;
  endtask

  // Called just after a negedge with inputs set: check this cycle, advance model, move to next negedge.
  task automatic cyc();
    int            w;
    logic [NM-1:0] eg, er;
    logic [39:0]   es, os;
    logic [31:0]   a;
    #1;
    w  = model_winner();
    eg = (w >= 0) ? NM'(1 << w) : '0;
    er = pv ? NM'(1 << pm) : '0;
    es = '0;
    if (w >= 0) begin
      a = addr_of(w);
      if (is_io(a))
        es = {1'b0, 17'h0, 1'b0, 8'h0, 1'b1, a[2:0], bus.m_wr_in[w], bus.m_dout_in[8*w +: 8]};
      else
        es = {1'b1, a[AW-1:0], bus.m_wr_in[w], bus.m_dout_in[8*w +: 8], 1'b0, 3'h0, 1'b0, 8'h0};
    end
    os = {bus.ram_en_out, bus.ram_a_out, bus.ram_wr_out, bus.ram_d_out,
          bus.io_en_out, bus.io_sel_out, bus.io_wr_out, bus.io_d_out};
    last_gnt  = bus.m_gnt_out;
    last_rv   = bus.m_rvalid_out;
    last_din  = bus.m_din_out;
    last_iowr = bus.io_wr_out;
    chk("gnt", bus.m_gnt_out, eg);
    chk("rvalid", bus.m_rvalid_out, er);
    chk("slave", os, es);
    if (pv) chk("rdata", bus.m_din_out, pio ? bus.io_d_in : bus.ram_d_in);
    if (rst) begin
      model_reset();
    end else begin
      pv = 0;
      if (w >= 0) begin
        mo_owner  = w;
        mo_locked = bus.m_lock_in[w];
`ifdef MEMBUS_RR_EN
        if (w != 0) mo_rr = w;
`endif
        if (!bus.m_wr_in[w]) begin
          pv  = 1;
          pm  = w;
          pio = is_io(addr_of(w));
        end
      end else if (!bus.pause_in) begin
        mo_locked = mo_locked && bus.m_req_in[mo_owner] && bus.m_lock_in[mo_owner];
      end
    end
    @(negedge clk);
  endtask

  initial begin
    logic [NM-1:0] g [5];
    rst = 1'b1;
    idle_all();
    bus.ram_d_in = 8'h00;
    bus.io_d_in  = 8'h00;
    model_reset();
    @(negedge clk);

    // reset state, with a request present
    set_m(1, 1'b1, 1'b0, 1'b0, 32'h10, 8'h0);
    cyc();
    rst = 1'b0;
    idle_all();
    cyc();

    // contention: master 0 first, master 1 the cycle after, read byte returned to master 0
    bus.ram_d_in = 8'hA5;
    set_m(0, 1'b1, 1'b0, 1'b0, 32'h00010, 8'h0);
    set_m(1, 1'b1, 1'b0, 1'b0, 32'h00010, 8'h0);
    cyc();
    chk("cont_m0_first", last_gnt, 4'b0001);
    set_m(0, 1'b0, 1'b0, 1'b0, 32'h0, 8'h0);
    cyc();
    chk("cont_m1_next", last_gnt, 4'b0010);
    chk("cont_rvalid_m0", last_rv, 4'b0001);
    chk("cont_rdata", last_din, 8'hA5);
    idle_all();
    cyc();

    // lock: master 1 keeps the bus for 4 cycles while master 0 waits
    for (int c = 0; c < 5; c++) begin
      set_m(1, 1'b1, (c < 3) ? 1'b1 : 1'b0, 1'b0, 32'h20, 8'h0);
      if (c >= 1) set_m(0, 1'b1, 1'b0, 1'b0, 32'h10, 8'h0);
      cyc();
      g[c] = last_gnt;
    end
    chk("lock_m1_x4", {g[0], g[1], g[2], g[3]}, {4{4'b0010}});
    chk("lock_m0_5th", g[4], 4'b0001);
    idle_all();
    cyc();

    // pause: in-flight read still returns, no new grant
    bus.ram_d_in = 8'h5A;
    set_m(2, 1'b1, 1'b0, 1'b0, 32'h40, 8'h0);
    cyc();
    bus.pause_in = 1'b1;
    cyc();
    chk("pause_no_gnt", last_gnt, 4'b0000);
    chk("pause_rvalid", last_rv, 4'b0100);
    idle_all();
    cyc();

    // IO backpressure: write waits while the buffer is full
    bus.io_full_in = 1'b1;
    set_m(1, 1'b1, 1'b0, 1'b1, 32'h30000, 8'h5C);
    for (int c = 0; c < 3; c++) begin
      cyc();
      g[c] = last_gnt;
    end
    chk("bp_stalled", {g[0], g[1], g[2]}, 12'h000);
    bus.io_full_in = 1'b0;
    cyc();
    chk("bp_gnt", last_gnt, 4'b0010);
    chk("bp_io_wr", last_iowr, 1'b1);
    idle_all();
    cyc();
    chk("bp_no_rvalid", last_rv, 4'b0000);

    // mixed return: IO read for master 1, RAM read for master 2, back to back
    bus.io_d_in  = 8'h3C;
    bus.ram_d_in = 8'h96;
    set_m(1, 1'b1, 1'b0, 1'b0, 32'h30000, 8'h0);
    cyc();
    set_m(1, 1'b0, 1'b0, 1'b0, 32'h0, 8'h0);
    set_m(2, 1'b1, 1'b0, 1'b0, 32'h4, 8'h0);
    cyc();
    chk("mix_gnt_m2", last_gnt, 4'b0100);
    chk("mix_rv_m1", last_rv, 4'b0010);
    chk("mix_io_data", last_din, 8'h3C);
    idle_all();
    cyc();
    chk("mix_rv_m2", last_rv, 4'b0100);
    chk("mix_ram_data", last_din, 8'h96);

    // async reset in the middle of a read return
    set_m(3, 1'b1, 1'b1, 1'b0, 32'h8, 8'h0);
    cyc();
    rst = 1'b1;
    #1;
    chk("rst_gnt", bus.m_gnt_out, 4'b0000);
    chk("rst_rvalid", bus.m_rvalid_out, 4'b0000);
    model_reset();
    cyc();
    rst = 1'b0;
    set_m(3, 1'b1, 1'b0, 1'b0, 32'h8, 8'h0);
    cyc();
    chk("rst_first_gnt", last_gnt, 4'b1000);
    idle_all();
    cyc();

    // masters 1..3 always requesting: round-robin or fixed priority
    for (int i = 1; i < NM; i++) set_m(i, 1'b1, 1'b0, 1'b0, 32'h100 + i, 8'h0);
    for (int c = 0; c < 4; c++) begin
      cyc();
      g[c] = last_gnt;
    end
`ifdef MEMBUS_RR_EN
    chk("rr_order", {g[0], g[1], g[2], g[3]}, {4'b0010, 4'b0100, 4'b1000, 4'b0010});
`else
    chk("fixed_order", {g[0], g[1], g[2], g[3]}, {4{4'b0010}});
`endif
    idle_all();
    cyc();

    // random traffic against the model
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NM; i++)
        set_m(i, $urandom_range(0, 99) < 55, $urandom_range(0, 99) < 30,
              $urandom_range(0, 99) < 40, $urandom, 8'($urandom));
      bus.pause_in   = $urandom_range(0, 99) < 8;
      bus.io_full_in = $urandom_range(0, 99) < 30;
      bus.ram_d_in   = 8'($urandom);
      bus.io_d_in    = 8'($urandom);
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
